// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        CALL_SEQ = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] SP_ADDR = 5'h1B;

    // The instruction now in EX is the youngest producer, so its result wins over MEM.
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_EXMEM;
        else if (mem_hit)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface ex_hazard_ctrl_if #(
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use1;
    logic            id_use2;
    logic            id_call_ret;
    logic [RA_W-1:0] ex_dest;
    logic            ex_regwrite;
    logic            ex_memread;
    logic [RA_W-1:0] mem_dest;
    logic            mem_regwrite;
    logic [RA_W-1:0] wb_dest;
    logic            wb_regwrite;
    logic            branch_taken;
    logic            stall_ifid;
    logic            flush_idex;
    logic            flush_ifid;
    logic [1:0]      fwd_sel1;
    logic [1:0]      fwd_sel2;
    logic            busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_call_ret,
        output ex_dest, ex_regwrite, ex_memread, mem_dest, mem_regwrite,
        output wb_dest, wb_regwrite, branch_taken,
        input  stall_ifid, flush_idex, flush_ifid, fwd_sel1, fwd_sel2, busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_call_ret,
        input  ex_dest, ex_regwrite, ex_memread, mem_dest, mem_regwrite,
        input  wb_dest, wb_regwrite, branch_taken,
        output stall_ifid, flush_idex, flush_ifid, fwd_sel1, fwd_sel2, busy
    );

endinterface

// File: rtl/ex_src_match.sv
// Compares one ID source register against the EX/MEM/WB writers.
// Build option EX_FWD_EN: produce a forward select and ignore the WB writer.
module ex_src_match
    import ex_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            i_used,
    input  logic [RA_W-1:0] i_rs,
    input  logic [RA_W-1:0] i_ex_dest,
    input  logic            i_ex_regwrite,
    input  logic [RA_W-1:0] i_mem_dest,
    input  logic            i_mem_regwrite,
    input  logic [RA_W-1:0] i_wb_dest,
    input  logic            i_wb_regwrite,
    output logic            o_ex_hit,
    output logic            o_mem_hit,
    output logic            o_wb_hit,
    output logic [1:0]      o_fwd_sel
);

    logic w_live;

    // Register 0 is hard-wired, so it can never create a dependency.
    assign w_live    = i_used && (i_rs != '0);
    assign o_ex_hit  = w_live && i_ex_regwrite  && (i_ex_dest  == i_rs);
    assign o_mem_hit = w_live && i_mem_regwrite && (i_mem_dest == i_rs);

`ifdef EX_FWD_EN
    logic w_unused_wb;
    assign w_unused_wb = ^{i_wb_dest, i_wb_regwrite};
    assign o_wb_hit    = 1'b0;
    assign o_fwd_sel   = fwd_pick(o_ex_hit, o_mem_hit);
`else
    assign o_wb_hit  = w_live && i_wb_regwrite && (i_wb_dest == i_rs);
    assign o_fwd_sel = FWD_RF;
`endif

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencer: load-use/RAW stalls, call/ret extra EX cycles, branch flushes, ALU forward selects.
// Build option EX_FWD_EN: forward from EX/MEM and MEM/WB; otherwise stall on every in-flight RAW hazard.
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int RA_W      = 5,
    parameter int SP_REG    = int'(SP_ADDR),
    parameter int CALL_XCYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    ex_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] XCYC = 2'(CALL_XCYC);

    if (CALL_XCYC < 1 || CALL_XCYC > 3 || SP_REG < 1 || SP_REG >= (1 << RA_W)) begin : g_bad_cfg
        $error("ex_hazard_ctrl: CALL_XCYC must be 1..3 and SP_REG a nonzero register index");
    end

    logic       w_ex_hit1, w_mem_hit1, w_wb_hit1;
    logic       w_ex_hit2, w_mem_hit2, w_wb_hit2;
    logic [1:0] w_fwd_sel1, w_fwd_sel2;

    ex_src_match #(.RA_W(RA_W)) u_src1 (
        .i_used         (bus.id_valid && bus.id_use1),
        .i_rs           (bus.id_rs1),
        .i_ex_dest      (bus.ex_dest),
        .i_ex_regwrite  (bus.ex_regwrite),
        .i_mem_dest     (bus.mem_dest),
        .i_mem_regwrite (bus.mem_regwrite),
        .i_wb_dest      (bus.wb_dest),
        .i_wb_regwrite  (bus.wb_regwrite),
        .o_ex_hit       (w_ex_hit1),
        .o_mem_hit      (w_mem_hit1),
        .o_wb_hit       (w_wb_hit1),
        .o_fwd_sel      (w_fwd_sel1)
    );

    ex_src_match #(.RA_W(RA_W)) u_src2 (
        .i_used         (bus.id_valid && bus.id_use2),
        .i_rs           (bus.id_rs2),
        .i_ex_dest      (bus.ex_dest),
        .i_ex_regwrite  (bus.ex_regwrite),
        .i_mem_dest     (bus.mem_dest),
        .i_mem_regwrite (bus.mem_regwrite),
        .i_wb_dest      (bus.wb_dest),
        .i_wb_regwrite  (bus.wb_regwrite),
        .o_ex_hit       (w_ex_hit2),
        .o_mem_hit      (w_mem_hit2),
        .o_wb_hit       (w_wb_hit2),
        .o_fwd_sel      (w_fwd_sel2)
    );

    state_t     r_state;
    logic [1:0] r_xcnt;
    logic [1:0] r_fwd_sel1, r_fwd_sel2;

    logic       w_load_use, w_raw_stall;
    logic       w_stall, w_flush_idex, w_flush_ifid;
    state_t     w_state_nxt;
    logic [1:0] w_xcnt_nxt;

    assign w_load_use = bus.id_valid && bus.ex_memread && (w_ex_hit1 || w_ex_hit2);

`ifdef EX_FWD_EN
    logic w_unused_hits;
    assign w_unused_hits = ^{w_mem_hit1, w_mem_hit2, w_wb_hit1, w_wb_hit2};
    assign w_raw_stall   = 1'b0;
`else
    assign w_raw_stall = w_ex_hit1 || w_mem_hit1 || w_wb_hit1 ||
                         w_ex_hit2 || w_mem_hit2 || w_wb_hit2;
`endif

    // Priority chain: reset, taken branch, load-use, call/ret sequence, plain RAW stall.
    always_comb begin
        w_stall      = 1'b0;
        w_flush_idex = 1'b0;
        w_flush_ifid = 1'b0;
        w_state_nxt  = RUN;
        w_xcnt_nxt   = '0;
        if (rst) begin
            w_state_nxt = RUN;
        end else if (bus.branch_taken) begin
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
        end else if (w_load_use) begin
            w_stall      = 1'b1;
            w_flush_idex = 1'b1;
            w_state_nxt  = LU_STALL;
        end else if (r_state == CALL_SEQ) begin
            w_stall      = 1'b1;
            w_flush_idex = 1'b1;
            w_xcnt_nxt   = r_xcnt - 2'd1;
            w_state_nxt  = (r_xcnt <= 2'd1) ? RUN : CALL_SEQ;
        end else if (w_raw_stall) begin
            w_stall      = 1'b1;
            w_flush_idex = 1'b1;
        end else if (bus.id_valid && bus.id_call_ret) begin
            w_state_nxt = CALL_SEQ;
            w_xcnt_nxt  = XCYC;
        end
    end

    // Forward selects belong to the instruction entering EX, so they only move when ID advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_xcnt     <= '0;
            r_fwd_sel1 <= FWD_RF;
            r_fwd_sel2 <= FWD_RF;
        end else begin
            r_state <= w_state_nxt;
            r_xcnt  <= w_xcnt_nxt;
            if (w_flush_idex) begin
                r_fwd_sel1 <= FWD_RF;
                r_fwd_sel2 <= FWD_RF;
            end else if (!w_stall) begin
                r_fwd_sel1 <= w_fwd_sel1;
                r_fwd_sel2 <= w_fwd_sel2;
            end
        end
    end

    assign bus.stall_ifid = w_stall;
    assign bus.flush_idex = w_flush_idex;
    assign bus.flush_ifid = w_flush_ifid;
    assign bus.fwd_sel1   = r_fwd_sel1;
    assign bus.fwd_sel2   = r_fwd_sel2;
    assign bus.busy       = (r_state != RUN);

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios plus random stimulus against a rule-level model.
// Expectations follow the EX_FWD_EN build option when it is defined.
module tb_ex_hazard_ctrl;
    import ex_ctrl_pkg::*;

    localparam int         XC = 1;
    localparam logic [4:0] SP = SP_ADDR;
`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ex_hazard_ctrl_if #(.RA_W(5)) bus ();

    ex_hazard_ctrl #(.RA_W(5), .SP_REG(27), .CALL_XCYC(XC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic setIdle();
        bus.id_valid     = 1'b0;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_use1      = 1'b0;
        bus.id_use2      = 1'b0;
        bus.id_call_ret  = 1'b0;
        bus.ex_dest      = '0;
        bus.ex_regwrite  = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.mem_dest     = '0;
        bus.mem_regwrite = 1'b0;
        bus.wb_dest      = '0;
        bus.wb_regwrite  = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        setIdle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Which stage holds the youngest writer of src: 0 none, 1 EX, 2 MEM, 3 WB.
    function automatic int hitStage(logic [4:0] src, logic used);
        if (!bus.id_valid || !used || src == 5'd0) return 0;
        if (bus.ex_regwrite && bus.ex_dest == src) return 1;
        if (bus.mem_regwrite && bus.mem_dest == src) return 2;
        if (bus.wb_regwrite && bus.wb_dest == src) return 3;
        return 0;
    endfunction

    function automatic logic [1:0] fwdCode(int stage);
        if (!FWD) return 2'b00;
        if (stage == 1) return 2'b01;
        if (stage == 2) return 2'b10;
        return 2'b00;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        setIdle();
        tick();
        bus.branch_taken = 1'b1;
        #2;
        total++; if (bus.flush_ifid !== 1'b0) begin bad++; $display("[TB] FAIL reset_beats_branch got=%0b want=0", bus.flush_ifid); end
        tick();
        bus.branch_taken = 1'b0;
        rst = 1'b0;
        #2;
        total++; if (bus.stall_ifid !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%0b want=0", bus.stall_ifid); end
        total++; if (bus.flush_idex !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush_idex got=%0b want=0", bus.flush_idex); end
        total++; if (bus.flush_ifid !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush_ifid got=%0b want=0", bus.flush_ifid); end
        total++; if (bus.fwd_sel1 !== 2'b00) begin bad++; $display("[TB] FAIL reset_fwd1 got=%0b want=00", bus.fwd_sel1); end
        total++; if (bus.fwd_sel2 !== 2'b00) begin bad++; $display("[TB] FAIL reset_fwd2 got=%0b want=00", bus.fwd_sel2); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", bus.busy); end
    endtask

    task automatic test_forward();
        doReset();
        bus.ex_dest = 5'd3; bus.ex_regwrite = 1'b1;
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd3; bus.id_use1 = 1'b1;
        #2;
        total++; if (bus.stall_ifid !== !FWD) begin bad++; $display("[TB] FAIL t1_stall got=%0b want=%0b", bus.stall_ifid, !FWD); end
        total++; if (bus.flush_idex !== !FWD) begin bad++; $display("[TB] FAIL t1_flush got=%0b want=%0b", bus.flush_idex, !FWD); end
        tick();
        setIdle();
        bus.mem_dest = 5'd9; bus.mem_regwrite = 1'b1;
        bus.id_valid = 1'b1; bus.id_rs2 = 5'd9; bus.id_use2 = 1'b1;
        #2;
        total++; if (bus.fwd_sel1 !== (FWD ? 2'b01 : 2'b00)) begin bad++; $display("[TB] FAIL t1_fwd1 got=%0b want=%0b", bus.fwd_sel1, FWD ? 2'b01 : 2'b00); end
        tick();
        setIdle();
        bus.ex_dest = 5'd4; bus.ex_regwrite = 1'b1; bus.mem_dest = 5'd4; bus.mem_regwrite = 1'b1;
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd4; bus.id_use1 = 1'b1;
        #2;
        if (!FWD) begin
            total++; if (bus.fwd_sel2 !== 2'b00) begin bad++; $display("[TB] FAIL mem_fwd2 got=%0b want=00", bus.fwd_sel2); end
        end else begin
            total++; if (bus.fwd_sel2 !== 2'b10) begin bad++; $display("[TB] FAIL mem_fwd2 got=%0b want=10", bus.fwd_sel2); end
        end
        tick();
        setIdle();
        #2;
        total++; if (bus.fwd_sel1 !== (FWD ? 2'b01 : 2'b00)) begin bad++; $display("[TB] FAIL youngest_fwd1 got=%0b want=%0b", bus.fwd_sel1, FWD ? 2'b01 : 2'b00); end
    endtask

    task automatic test_load_use();
        doReset();
        bus.ex_dest = 5'd5; bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1;
        bus.id_valid = 1'b1; bus.id_rs2 = 5'd5; bus.id_use2 = 1'b1;
        #2;
        total++; if (bus.stall_ifid !== 1'b1) begin bad++; $display("[TB] FAIL t2_stall got=%0b want=1", bus.stall_ifid); end
        total++; if (bus.flush_idex !== 1'b1) begin bad++; $display("[TB] FAIL t2_flush got=%0b want=1", bus.flush_idex); end
        total++; if (bus.flush_ifid !== 1'b0) begin bad++; $display("[TB] FAIL t2_flush_ifid got=%0b want=0", bus.flush_ifid); end
        tick();
        bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0; bus.ex_dest = 5'd0;
        bus.mem_dest = 5'd5; bus.mem_regwrite = 1'b1;
        #2;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL t2_busy got=%0b want=1", bus.busy); end
        total++; if (bus.stall_ifid !== !FWD) begin bad++; $display("[TB] FAIL t2_after_stall got=%0b want=%0b", bus.stall_ifid, !FWD); end
        total++; if (bus.fwd_sel2 !== 2'b00) begin bad++; $display("[TB] FAIL t2_bubble_fwd2 got=%0b want=00", bus.fwd_sel2); end
        tick();
        setIdle();
        #2;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL t2_busy_end got=%0b want=0", bus.busy); end
        total++; if (bus.fwd_sel2 !== (FWD ? 2'b10 : 2'b00)) begin bad++; $display("[TB] FAIL t2_fwd2 got=%0b want=%0b", bus.fwd_sel2, FWD ? 2'b10 : 2'b00); end
    endtask

    task automatic test_reg0();
        doReset();
        bus.ex_dest = 5'd0; bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1;
        bus.mem_dest = 5'd0; bus.mem_regwrite = 1'b1;
        bus.wb_dest = 5'd0; bus.wb_regwrite = 1'b1;
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd0; bus.id_use1 = 1'b1;
        #2;
        total++; if (bus.stall_ifid !== 1'b0) begin bad++; $display("[TB] FAIL t3_stall got=%0b want=0", bus.stall_ifid); end
        total++; if (bus.flush_idex !== 1'b0) begin bad++; $display("[TB] FAIL t3_flush got=%0b want=0", bus.flush_idex); end
        tick();
        setIdle();
        #2;
        total++; if (bus.fwd_sel1 !== 2'b00) begin bad++; $display("[TB] FAIL t3_fwd1 got=%0b want=00", bus.fwd_sel1); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL t3_busy got=%0b want=0", bus.busy); end
    endtask

    task automatic test_call();
        doReset();
        bus.id_valid = 1'b1; bus.id_call_ret = 1'b1; bus.id_rs1 = SP; bus.id_use1 = 1'b1;
        #2;
        total++; if (bus.stall_ifid !== 1'b0) begin bad++; $display("[TB] FAIL t4_issue_stall got=%0b want=0", bus.stall_ifid); end
        tick();
        bus.ex_dest = SP; bus.ex_regwrite = 1'b1;
        #2;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL t4_busy got=%0b want=1", bus.busy); end
        total++; if (bus.stall_ifid !== 1'b1) begin bad++; $display("[TB] FAIL t4_stall got=%0b want=1", bus.stall_ifid); end
        total++; if (bus.flush_idex !== 1'b1) begin bad++; $display("[TB] FAIL t4_flush got=%0b want=1", bus.flush_idex); end
        tick();
        bus.ex_dest = 5'd0; bus.ex_regwrite = 1'b0;
        bus.mem_dest = SP; bus.mem_regwrite = 1'b1;
        #2;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL t4_run got=%0b want=0", bus.busy); end
        total++; if (bus.stall_ifid !== !FWD) begin bad++; $display("[TB] FAIL t4_ret_stall got=%0b want=%0b", bus.stall_ifid, !FWD); end
        tick();
        setIdle();
        #2;
        total++; if (bus.busy !== FWD) begin bad++; $display("[TB] FAIL t4_ret_busy got=%0b want=%0b", bus.busy, FWD); end
        total++; if (bus.fwd_sel1 !== (FWD ? 2'b10 : 2'b00)) begin bad++; $display("[TB] FAIL t4_ret_fwd1 got=%0b want=%0b", bus.fwd_sel1, FWD ? 2'b10 : 2'b00); end
        tick();
        #2;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL t4_end_busy got=%0b want=0", bus.busy); end
    endtask

    task automatic test_branch_in_lu();
        doReset();
        bus.ex_dest = 5'd6; bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1;
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd6; bus.id_use1 = 1'b1;
        #2;
        total++; if (bus.stall_ifid !== 1'b1) begin bad++; $display("[TB] FAIL t5_lu_stall got=%0b want=1", bus.stall_ifid); end
        tick();
        bus.branch_taken = 1'b1;
        #2;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL t5_busy got=%0b want=1", bus.busy); end
        total++; if (bus.stall_ifid !== 1'b0) begin bad++; $display("[TB] FAIL t5_stall got=%0b want=0", bus.stall_ifid); end
        total++; if (bus.flush_idex !== 1'b1) begin bad++; $display("[TB] FAIL t5_flush_idex got=%0b want=1", bus.flush_idex); end
        total++; if (bus.flush_ifid !== 1'b1) begin bad++; $display("[TB] FAIL t5_flush_ifid got=%0b want=1", bus.flush_ifid); end
        tick();
        setIdle();
        #2;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL t5_run got=%0b want=0", bus.busy); end
        total++; if (bus.flush_ifid !== 1'b0) begin bad++; $display("[TB] FAIL t5_flush_end got=%0b want=0", bus.flush_ifid); end
    endtask

    task automatic test_reset_in_call();
        doReset();
        bus.id_valid = 1'b1; bus.id_call_ret = 1'b1;
        tick();
        bus.ex_dest = SP; bus.ex_regwrite = 1'b1;
        rst = 1'b1;
        #2;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL t6_seq_busy got=%0b want=1", bus.busy); end
        tick();
        rst = 1'b0;
        setIdle();
        #2;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL t6_busy got=%0b want=0", bus.busy); end
        total++; if (bus.stall_ifid !== 1'b0) begin bad++; $display("[TB] FAIL t6_stall got=%0b want=0", bus.stall_ifid); end
        total++; if (bus.flush_idex !== 1'b0) begin bad++; $display("[TB] FAIL t6_flush got=%0b want=0", bus.flush_idex); end
        total++; if (bus.fwd_sel1 !== 2'b00) begin bad++; $display("[TB] FAIL t6_fwd1 got=%0b want=00", bus.fwd_sel1); end
    endtask

    task automatic test_raw_wb();
        logic [1:0] wantFwd [4];
        doReset();
        wantFwd[0] = 2'b00;
        wantFwd[1] = FWD ? 2'b01 : 2'b00;
        wantFwd[2] = FWD ? 2'b10 : 2'b00;
        wantFwd[3] = 2'b00;
        for (int k = 0; k < 4; k++) begin
            setIdle();
            bus.id_valid = 1'b1; bus.id_rs1 = 5'd7; bus.id_use1 = 1'b1;
            if (k == 0) begin bus.ex_dest = 5'd7; bus.ex_regwrite = 1'b1; end
            if (k == 1) begin bus.mem_dest = 5'd7; bus.mem_regwrite = 1'b1; end
            if (k == 2) begin bus.wb_dest = 5'd7; bus.wb_regwrite = 1'b1; end
            #2;
            total++; if (bus.stall_ifid !== (!FWD && k < 3)) begin bad++; $display("[TB] FAIL raw_r7_stall[%0d] got=%0b want=%0b", k, bus.stall_ifid, !FWD && k < 3); end
            total++; if (bus.fwd_sel1 !== wantFwd[k]) begin bad++; $display("[TB] FAIL raw_r7_fwd1[%0d] got=%0b want=%0b", k, bus.fwd_sel1, wantFwd[k]); end
            tick();
        end
        setIdle();
    endtask

    task automatic test_random();
        int         mLeft, nextLeft, h1, h2;
        bit         mLu, lu, raw, eStall, eFlushIdex, eFlushIfid, eBusy;
        logic [1:0] mF1, mF2;
        doReset();
        mLeft = 0; mLu = 1'b0; mF1 = 2'b00; mF2 = 2'b00;
        for (int n = 0; n < 600; n++) begin
            rst              = ($urandom_range(0, 63) == 0);
            bus.id_valid     = ($urandom_range(0, 3) != 0);
            bus.id_rs1       = 5'($urandom_range(0, 7));
            bus.id_rs2       = 5'($urandom_range(0, 7));
            bus.id_use1      = ($urandom_range(0, 3) != 0);
            bus.id_use2      = ($urandom_range(0, 1) != 0);
            bus.id_call_ret  = ($urandom_range(0, 4) == 0);
            bus.ex_dest      = 5'($urandom_range(0, 7));
            bus.ex_regwrite  = ($urandom_range(0, 1) != 0);
            bus.ex_memread   = ($urandom_range(0, 2) == 0);
            bus.mem_dest     = 5'($urandom_range(0, 7));
            bus.mem_regwrite = ($urandom_range(0, 1) != 0);
            bus.wb_dest      = 5'($urandom_range(0, 7));
            bus.wb_regwrite  = ($urandom_range(0, 1) != 0);
            bus.branch_taken = ($urandom_range(0, 11) == 0);

            h1  = hitStage(bus.id_rs1, bus.id_use1);
            h2  = hitStage(bus.id_rs2, bus.id_use2);
            lu  = bus.id_valid && bus.ex_memread && bus.ex_regwrite && bus.ex_dest != 5'd0 &&
                  ((bus.id_use1 && bus.id_rs1 == bus.ex_dest) || (bus.id_use2 && bus.id_rs2 == bus.ex_dest));
            raw = !FWD && (h1 != 0 || h2 != 0);

            eFlushIfid = !rst && bus.branch_taken;
            eStall     = !rst && !bus.branch_taken && (lu || mLeft > 0 || raw);
            eFlushIdex = eStall || eFlushIfid;
            eBusy      = mLu || (mLeft > 0);

            #2;
            total++; if (bus.stall_ifid !== eStall) begin bad++; $display("[TB] FAIL rnd_stall n=%0d got=%0b want=%0b", n, bus.stall_ifid, eStall); end
            total++; if (bus.flush_idex !== eFlushIdex) begin bad++; $display("[TB] FAIL rnd_flush_idex n=%0d got=%0b want=%0b", n, bus.flush_idex, eFlushIdex); end
            total++; if (bus.flush_ifid !== eFlushIfid) begin bad++; $display("[TB] FAIL rnd_flush_ifid n=%0d got=%0b want=%0b", n, bus.flush_ifid, eFlushIfid); end
            total++; if (bus.busy !== eBusy) begin bad++; $display("[TB] FAIL rnd_busy n=%0d got=%0b want=%0b", n, bus.busy, eBusy); end
            total++; if (bus.fwd_sel1 !== mF1) begin bad++; $display("[TB] FAIL rnd_fwd1 n=%0d got=%0b want=%0b", n, bus.fwd_sel1, mF1); end
            total++; if (bus.fwd_sel2 !== mF2) begin bad++; $display("[TB] FAIL rnd_fwd2 n=%0d got=%0b want=%0b", n, bus.fwd_sel2, mF2); end

            if (rst) begin
                mLeft = 0; mLu = 1'b0; mF1 = 2'b00; mF2 = 2'b00;
            end else begin
                if (bus.branch_taken || lu) nextLeft = 0;
                else if (mLeft > 0) nextLeft = mLeft - 1;
                else if (raw) nextLeft = 0;
                else if (bus.id_valid && bus.id_call_ret) nextLeft = XC;
                else nextLeft = 0;
                mLu = !bus.branch_taken && lu;
                if (eFlushIdex) begin
                    mF1 = 2'b00; mF2 = 2'b00;
                end else begin
                    mF1 = fwdCode(h1); mF2 = fwdCode(h2);
                end
                mLeft = nextLeft;
            end
            tick();
        end
        rst = 1'b0;
        setIdle();
    endtask

    initial begin
        rst = 1'b1;
        setIdle();
        test_reset();
        test_forward();
        test_load_use();
        test_reg0();
        test_call();
        test_branch_in_lu();
        test_reset_in_call();
        test_raw_wb();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
